// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the memory port arbiter.
//   - Default address and data widths.
//   - FSM state encoding.
//   - Owner (requester) encoding.
package mem_arb_pkg;

  localparam int unsigned DefAddrW = 14;
  localparam int unsigned DefDataW = 32;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StDone  = 2'd3
  } arb_state_e;

  typedef enum logic [1:0] {
    OwnNone = 2'd0,
    OwnLd   = 2'd1,
    OwnD    = 2'd2,
    OwnI    = 2'd3
  } owner_e;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner selection for the memory port arbiter.
// Ports:
//   prog_mode - loader owns the RAM; CPU ports are ineligible
//   ld_req    - loader request
//   d_req     - CPU data request
//   i_req     - CPU fetch request
//   starve    - fetch has been passed over the maximum number of times
//   winner    - owner code of the selected requester (OwnNone if none)
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic   prog_mode,
  input  logic   ld_req,
  input  logic   d_req,
  input  logic   i_req,
  input  logic   starve,
  output owner_e winner
);

  always_comb begin
    winner = OwnNone;
    if (prog_mode) begin
      if (ld_req) begin
        winner = OwnLd;
      end
    end else if (i_req && (starve || !d_req)) begin
      // Fetch wins when uncontested or when the starvation guard has tripped.
      winner = OwnI;
    end else if (d_req) begin
      winner = OwnD;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between the program loader (ld), the CPU data port (d)
// and the CPU fetch port (i). One access at a time: IDLE -> ISSUE -> WAIT (RAM_LAT) -> DONE.
// Ports:
//   clk, rst                       - clock, synchronous active-high reset
//   prog_mode                      - loader owns the RAM, CPU ports never granted
//   ld_req/ld_addr/ld_wdata/ld_ack - loader write port
//   d_req/d_we/d_addr/d_wdata/d_ack - CPU data port
//   i_req/i_addr/i_ack             - CPU fetch port (read only)
//   rdata                          - read data, valid in the ack cycle, held between accesses
//   ram_en/ram_we/ram_addr/ram_wdata/ram_rdata - registered RAM interface
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = DefAddrW,
  parameter int unsigned DATA_W     = DefDataW,
  parameter int unsigned RAM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prog_mode,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int unsigned WaitW   = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;
  localparam int unsigned StarveW = $clog2(STARVE_MAX + 1);

  localparam logic [WaitW-1:0]   WaitLoad  = WaitW'(RAM_LAT - 1);
  localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_MAX);

  arb_state_e state_q, state_d;
  owner_e     owner_q, owner_d;
  owner_e     winner;

  logic [WaitW-1:0]   wait_q, wait_d;
  logic [StarveW-1:0] starve_q, starve_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;

  logic              ram_en_q, ram_en_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;

  logic starve;
  logic grant;

  assign starve = (starve_q == StarveMax);
  // Arbitration only takes effect in IDLE; elsewhere the winner is ignored.
  assign grant  = (state_q == StIdle) && (winner != OwnNone);

  arb_pick u_arb_pick (
    .prog_mode (prog_mode),
    .ld_req    (ld_req),
    .d_req     (d_req),
    .i_req     (i_req),
    .starve    (starve),
    .winner    (winner)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (winner != OwnNone) state_d = StIssue;
      StIssue: state_d = StWait;
      StWait:  if (wait_q == '0) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs: acks decoded from state and owner, so at most one is ever high.
  always_comb begin
    ld_ack    = (state_q == StDone) && (owner_q == OwnLd);
    d_ack     = (state_q == StDone) && (owner_q == OwnD);
    i_ack     = (state_q == StDone) && (owner_q == OwnI);
    rdata     = rdata_q;
    ram_en    = ram_en_q;
    ram_we    = ram_we_q;
    ram_addr  = ram_addr_q;
    ram_wdata = ram_wdata_q;
  end

  // Datapath next-state
  always_comb begin
    owner_d     = owner_q;
    wait_d      = wait_q;
    starve_d    = starve_q;
    rdata_d     = rdata_q;
    ram_en_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;

    if (grant) begin
      owner_d  = winner;
      ram_en_d = 1'b1;
      unique case (winner)
        OwnLd: begin
          ram_we_d    = 1'b1;
          ram_addr_d  = ld_addr;
          ram_wdata_d = ld_wdata;
        end
        OwnD: begin
          ram_we_d    = d_we;
          ram_addr_d  = d_addr;
          ram_wdata_d = d_wdata;
        end
        OwnI: begin
          ram_we_d    = 1'b0;
          ram_addr_d  = i_addr;
          ram_wdata_d = '0;
        end
        default: ;
      endcase
      // Count d grants that leave a fetch waiting; any other grant resets the streak.
      if ((winner == OwnD) && i_req) begin
        if (!starve) begin
          starve_d = starve_q + StarveW'(1);
        end
      end else begin
        starve_d = '0;
      end
    end

    if (state_q == StIssue) begin
      wait_d = WaitLoad;
    end

    if (state_q == StWait) begin
      if (wait_q == '0) begin
        // Captured on writes too; the value is simply unused then.
        rdata_d = ram_rdata;
      end else begin
        wait_d = wait_q - WaitW'(1);
      end
    end

    if (state_q == StDone) begin
      owner_d = OwnNone;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q     <= OwnNone;
      wait_q      <= '0;
      starve_q    <= '0;
      rdata_q     <= '0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      owner_q     <= owner_d;
      wait_q      <= wait_d;
      starve_q    <= starve_d;
      rdata_q     <= rdata_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by random traffic, every cycle checked
// against a transaction-level model (grant rule + fixed access latency + shadow memory).
module tb_mem_port_arbiter;

  localparam int LAT  = 1;
  localparam int SMAX = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        prog_mode = 1'b0;
  logic        ld_req = 1'b0;
  logic [13:0] ld_addr = '0;
  logic [31:0] ld_wdata = '0;
  logic        ld_ack;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [13:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_ack;
  logic        i_req = 1'b0;
  logic [13:0] i_addr = '0;
  logic        i_ack;
  logic [31:0] rdata;
  logic        ram_en;
  logic        ram_we;
  logic [13:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W     (14),
    .DATA_W     (32),
    .RAM_LAT    (LAT),
    .STARVE_MAX (SMAX)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .prog_mode (prog_mode),
    .ld_req    (ld_req),
    .ld_addr   (ld_addr),
    .ld_wdata  (ld_wdata),
    .ld_ack    (ld_ack),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ack     (d_ack),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_ack     (i_ack),
    .rdata     (rdata),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  // Single-port RAM with one cycle read latency, plus a backdoor for preloading.
  logic [31:0] ram_mem [0:16383];
  logic [31:0] ram_rd;
  logic        bd_we = 1'b0;
  logic [13:0] bd_addr = '0;
  logic [31:0] bd_data = '0;

  always @(posedge clk) begin
    if (bd_we) ram_mem[bd_addr] <= bd_data;
    if (ram_en) begin
      if (ram_we) ram_mem[ram_addr] <= ram_wdata;
      ram_rd <= ram_mem[ram_addr];
    end
  end
  assign ram_rdata = ram_rd;

  // Model state: owners are 0 none, 1 ld, 2 d, 3 i; m_t counts cycles since the grant.
  logic [31:0] ref_mem [0:16383];
  int          m_t = 0;
  int          m_own = 0;
  int          m_streak = 0;
  logic [13:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_we;
  logic [31:0] m_exp;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  bit          keep_req = 0;
  int          ack_log[$];
  int          last_own = 0;
  int          last_cyc = -1;
  logic [31:0] last_rdata;
  int          n_i_acks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int pick(bit pm, bit l, bit d, bit i, int streak);
    if (pm) return l ? 1 : 0;
    if (i && (!d || streak >= SMAX)) return 3;
    if (d) return 2;
    return 0;
  endfunction

  // Advance the model with this cycle's inputs, clock once, then check the new cycle's outputs.
  task automatic step();
    bit was_rst;
    int w;
    int eack;
    was_rst = rst;
    if (rst) begin
      m_t = 0;
      m_streak = 0;
    end else if (m_t == 0) begin
      w = pick(prog_mode, ld_req, d_req, i_req, m_streak);
      if (w != 0) begin
        m_own = w;
        m_t = 1;
        if (w == 1) begin
          m_addr = ld_addr; m_we = 1'b1; m_wdata = ld_wdata;
        end else if (w == 2) begin
          m_addr = d_addr; m_we = d_we; m_wdata = d_wdata;
        end else begin
          m_addr = i_addr; m_we = 1'b0; m_wdata = '0;
        end
        if (m_we) ref_mem[m_addr] = m_wdata;
        else m_exp = ref_mem[m_addr];
        if (w == 2 && i_req) m_streak = (m_streak < SMAX) ? m_streak + 1 : SMAX;
        else m_streak = 0;
      end
    end else if (m_t == 2 + LAT) begin
      m_t = 0;
    end else begin
      m_t++;
    end

    @(posedge clk);
    #1;
    cyc++;

    if (was_rst) begin
      chk("rst_ram_en", 32'(ram_en), 32'd0);
      chk("rst_ram_we", 32'(ram_we), 32'd0);
      chk("rst_ram_addr", 32'(ram_addr), 32'd0);
      chk("rst_ram_wdata", ram_wdata, 32'd0);
      chk("rst_acks", {29'd0, ld_ack, d_ack, i_ack}, 32'd0);
      chk("rst_rdata", rdata, 32'd0);
    end else begin
      eack = (m_t == 2 + LAT) ? m_own : 0;
      chk("ram_en", 32'(ram_en), 32'(m_t == 1));
      if (m_t == 1) begin
        chk("ram_we", 32'(ram_we), 32'(m_we));
        chk("ram_addr", 32'(ram_addr), 32'(m_addr));
        if (m_we) chk("ram_wdata", ram_wdata, m_wdata);
      end
      chk("ld_ack", 32'(ld_ack), 32'(eack == 1));
      chk("d_ack", 32'(d_ack), 32'(eack == 2));
      chk("i_ack", 32'(i_ack), 32'(eack == 3));
      if (eack != 0 && !m_we) chk("rdata", rdata, m_exp);
    end

    if (ld_ack) begin
      ack_log.push_back(1); last_own = 1; last_cyc = cyc; last_rdata = rdata;
      if (!keep_req) ld_req = 1'b0;
    end
    if (d_ack) begin
      ack_log.push_back(2); last_own = 2; last_cyc = cyc; last_rdata = rdata;
      if (!keep_req) d_req = 1'b0;
    end
    if (i_ack) begin
      ack_log.push_back(3); last_own = 3; last_cyc = cyc; last_rdata = rdata;
      n_i_acks++;
      if (!keep_req) i_req = 1'b0;
    end
  endtask

  task automatic run_until(input int own, input int max_cyc, output int at);
    at = -1;
    for (int k = 0; k < max_cyc; k++) begin
      step();
      if (last_own == own && last_cyc == cyc) begin
        at = cyc;
        break;
      end
    end
    chk($sformatf("ack_seen_own%0d", own), 32'(at >= 0), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    prog_mode = 1'b0;
    ld_req = 1'b0;
    d_req = 1'b0;
    i_req = 1'b0;
    keep_req = 0;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout cycle=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int at;
    int at2;
    int saved;
    int exp_seq[10];
    logic [31:0] v;

    // Preload words 0..63 while reset is held.
    for (int k = 0; k < 64; k++) begin
      v = $urandom;
      if (k == 'h10) v = 32'h24080005;
      if (k == 'h30) v = 32'h13572468;
      bd_we = 1'b1; bd_addr = 14'(k); bd_data = v; ref_mem[k] = v;
      @(posedge clk);
      #1;
    end
    bd_we = 1'b0;
    do_reset();

    // Single fetch.
    i_req = 1'b1; i_addr = 14'h0010;
    n = cyc;
    run_until(3, 10, at);
    chk("fetch_latency", 32'(at - n), 32'd3);
    chk("fetch_rdata", last_rdata, 32'h24080005);

    // Simultaneous d write and i read.
    do_reset();
    d_req = 1'b1; d_we = 1'b1; d_addr = 14'h0020; d_wdata = 32'hCAFEF00D;
    i_req = 1'b1; i_addr = 14'h0004;
    n = cyc;
    run_until(2, 10, at);
    chk("dw_latency", 32'(at - n), 32'd3);
    run_until(3, 10, at2);
    chk("i_after_d_latency", 32'(at2 - n), 32'd7);
    chk("ram_word_20", ram_mem[14'h0020], 32'hCAFEF00D);

    // Starvation guard with d and i held continuously.
    do_reset();
    exp_seq = '{2, 2, 2, 2, 3, 2, 2, 2, 2, 3};
    ack_log.delete();
    keep_req = 1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 14'd1;
    i_req = 1'b1; i_addr = 14'd2;
    for (int k = 0; k < 100 && ack_log.size() < 10; k++) step();
    keep_req = 0;
    d_req = 1'b0; i_req = 1'b0;
    chk("starve_count", 32'(ack_log.size()), 32'd10);
    for (int k = 0; k < 10 && k < ack_log.size(); k++)
      chk($sformatf("starve_order%0d", k), 32'(ack_log[k]), 32'(exp_seq[k]));

    // Programming mode.
    do_reset();
    prog_mode = 1'b1;
    ld_req = 1'b1; ld_addr = 14'd5; ld_wdata = 32'hDEADBEEF;
    i_req = 1'b1; i_addr = 14'd3;
    saved = n_i_acks;
    run_until(1, 10, at);
    for (int k = 0; k < 6; k++) step();
    chk("prog_no_i_ack", 32'(n_i_acks - saved), 32'd0);
    chk("ram_word_5", ram_mem[14'd5], 32'hDEADBEEF);
    prog_mode = 1'b0;
    n = cyc;
    run_until(3, 10, at);
    chk("post_prog_i_latency", 32'(at - n), 32'd3);

    // Mode change during the WAIT of a d read.
    do_reset();
    d_req = 1'b1; d_we = 1'b0; d_addr = 14'h0030;
    step();
    step();
    prog_mode = 1'b1;
    ld_req = 1'b1; ld_addr = 14'd7; ld_wdata = $urandom;
    i_req = 1'b1; i_addr = 14'd8;
    saved = n_i_acks;
    run_until(2, 10, at);
    chk("mode_chg_rdata", last_rdata, 32'h13572468);
    run_until(1, 10, at);
    chk("mode_chg_no_i", 32'(n_i_acks - saved), 32'd0);
    prog_mode = 1'b0;
    i_req = 1'b0;

    // Reset in the WAIT of a fetch.
    do_reset();
    i_req = 1'b1; i_addr = 14'd9;
    step();
    step();
    rst = 1'b1; i_req = 1'b0;
    saved = n_i_acks;
    step();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) step();
    chk("abort_no_ack", 32'(n_i_acks - saved), 32'd0);
    i_req = 1'b1; i_addr = 14'h0010;
    n = cyc;
    run_until(3, 10, at);
    chk("post_rst_latency", 32'(at - n), 32'd3);

    // Random traffic.
    do_reset();
    for (int k = 0; k < 800; k++) begin
      if (!ld_req && $urandom_range(0, 3) == 0) begin
        ld_req = 1'b1; ld_addr = 14'($urandom_range(0, 31)); ld_wdata = $urandom;
      end
      if (!d_req && $urandom_range(0, 2) == 0) begin
        d_req = 1'b1; d_we = 1'($urandom_range(0, 1));
        d_addr = 14'($urandom_range(0, 31)); d_wdata = $urandom;
      end
      if (!i_req && $urandom_range(0, 1) == 0) begin
        i_req = 1'b1; i_addr = 14'($urandom_range(0, 31));
      end
      if ($urandom_range(0, 39) == 0) prog_mode = ~prog_mode;
      step();
    end
    prog_mode = 1'b0;
    ld_req = 1'b0;
    for (int k = 0; k < 30; k++) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
